// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 prefix codes and frame-state type for the key decoder.
package ps2_pkg;
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;
endpackage

// File: rtl/ps2_edge_filter.sv
// ps2_edge_filter: synchronizes raw PS/2 lines, glitch-filters ps2_clk, emits a falling-edge pulse.
// Ports: clk, rst_n (sync, active-low); ps2_clk/ps2_data raw async lines;
//        fall = one-cycle pulse on filtered ps2_clk falling edge; data = synchronized ps2_data.
module ps2_edge_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] clk_s, dat_s;
  logic level;
  logic [CW-1:0] cnt;
  logic done;
  // the filtered level flips only after FILTER_LEN consecutive samples disagree with it
  assign done = clk_s[1] != level && cnt == CW'(FILTER_LEN - 1);
  assign data = dat_s[1];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s <= '0;
      dat_s <= '0;
      level <= 1'b0;
      cnt <= '0;
      fall <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      cnt <= (clk_s[1] == level || done) ? '0 : cnt + 1'b1;
      level <= done ? clk_s[1] : level;
      fall <= done && level;
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard frame receiver with E0/F0 prefix decode and held-key map.
// Ports: clk, rst_n (sync, active-low); ps2_clk/ps2_data raw async lines;
//        last_change/key_extended/key_make updated with one-cycle key_valid pulse;
//        any_key_down = any non-extended code < 80h held; frame_err = one-cycle pulse on discarded frame.
// Macro PS2_PARITY_CHECK_EN: when defined, odd parity is enforced; otherwise the parity bit is ignored.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] last_change,
  output logic       key_extended,
  output logic       key_make,
  output logic       key_valid,
  output logic       any_key_down,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  ps2_state_e state, state_d;
  logic fall, data, par, par_ok, timeout, accept, err, ext, brk, is_prefix;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic [TW-1:0] tmo;
  logic [127:0] held;
  ps2_edge_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk(clk),
    .rst_n(rst_n),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .fall(fall),
    .data(data)
  );
`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shift, par};
`else
  // parity bit is captured but never rejects a frame
  assign par_ok = par | 1'b1;
`endif
  assign timeout = state != IDLE && !fall && tmo == TW'(TIMEOUT_CYC - 1);
  assign is_prefix = shift == PS2_PREFIX_EXT || shift == PS2_PREFIX_BREAK;
  always_comb begin
    state_d = state;
    accept = 1'b0;
    err = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      err = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:    state_d = data ? IDLE : DATA;
        DATA:    state_d = bit_cnt == 3'd7 ? PARITY : DATA;
        PARITY:  state_d = STOP;
        default: begin
          state_d = IDLE;
          accept = data && par_ok;
          err = !(data && par_ok);
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      shift <= '0;
      bit_cnt <= '0;
      par <= 1'b0;
      tmo <= '0;
      ext <= 1'b0;
      brk <= 1'b0;
      held <= '0;
      last_change <= '0;
      key_extended <= 1'b0;
      key_make <= 1'b0;
      key_valid <= 1'b0;
      any_key_down <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_d;
      tmo <= (fall || state == IDLE) ? '0 : tmo + 1'b1;
      if (fall && state == IDLE) bit_cnt <= '0;
      if (fall && state == DATA) begin
        shift <= {data, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (fall && state == PARITY) par <= data;
      frame_err <= err;
      key_valid <= accept && !is_prefix;
      any_key_down <= |held;
      if (accept) begin
        if (shift == PS2_PREFIX_EXT) ext <= 1'b1;
        else if (shift == PS2_PREFIX_BREAK) brk <= 1'b1;
        else begin
          last_change <= shift;
          key_extended <= ext;
          key_make <= ~brk;
          ext <= 1'b0;
          brk <= 1'b0;
          if (!ext && !shift[7]) held[shift[6:0]] <= ~brk;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed self-checking bench for ps2_key_decoder.
module tb_ps2_key_decoder;
  localparam int H = 20;
  localparam int TMO = 200;
  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] last_change;
  logic key_extended, key_make, key_valid, any_key_down, frame_err;
  int n_cmp = 0, n_err = 0, kv_cnt = 0, fe_cnt = 0, kv0 = 0, fe0 = 0;

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .last_change(last_change),
    .key_extended(key_extended),
    .key_make(key_make),
    .key_valid(key_valid),
    .any_key_down(any_key_down),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // pulse widths are counted in cycles, so a one-cycle pulse adds exactly 1
  always @(negedge clk) begin
    if (key_valid === 1'b1) kv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (H) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic pflip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ pflip);
    send_bit(stop);
    ps2_data = 1'b1;
    repeat (3 * H) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mark();
    kv0 = kv_cnt;
    fe0 = fe_cnt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({last_change, key_extended, key_make, key_valid, any_key_down, frame_err} !== 13'h0) begin
      n_err++;
      $display("FAIL reset_vals: got %h want 0000", {last_change, key_extended, key_make, key_valid, any_key_down, frame_err});
    end
    rst_n = 1'b1;
    mark();
    repeat (4 * H) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (kv_cnt - kv0 !== 0 || fe_cnt - fe0 !== 0 || last_change !== 8'h00) begin
      n_err++;
      $display("FAIL reset_idle: kv=%0d fe=%0d last=%h want 0 0 00", kv_cnt - kv0, fe_cnt - fe0, last_change);
    end
  endtask

  task automatic test_make();
    mark();
    send_frame(8'h15, 1'b1, 1'b0);
    n_cmp++;
    if (kv_cnt - kv0 !== 1 || fe_cnt - fe0 !== 0) begin
      n_err++;
      $display("FAIL make_pulse: kv=%0d fe=%0d want 1 0", kv_cnt - kv0, fe_cnt - fe0);
    end
    n_cmp++;
    if ({last_change, key_extended, key_make, any_key_down} !== {8'h15, 3'b011}) begin
      n_err++;
      $display("FAIL make_out: got %h want %h", {last_change, key_extended, key_make, any_key_down}, {8'h15, 3'b011});
    end
  endtask

  task automatic test_break();
    mark();
    send_frame(8'hF0, 1'b1, 1'b0);
    n_cmp++;
    if (kv_cnt - kv0 !== 0) begin
      n_err++;
      $display("FAIL break_prefix: kv=%0d want 0", kv_cnt - kv0);
    end
    send_frame(8'h15, 1'b1, 1'b0);
    n_cmp++;
    if (kv_cnt - kv0 !== 1 || {last_change, key_extended, key_make, any_key_down} !== {8'h15, 3'b000}) begin
      n_err++;
      $display("FAIL break_out: kv=%0d out=%h want 1 %h", kv_cnt - kv0, {last_change, key_extended, key_make, any_key_down}, {8'h15, 3'b000});
    end
  endtask

  task automatic test_extended();
    send_frame(8'h1C, 1'b1, 1'b0);
    mark();
    send_frame(8'hE0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b1, 1'b0);
    n_cmp++;
    if (kv_cnt - kv0 !== 1 || {last_change, key_extended, key_make, any_key_down} !== {8'h75, 3'b101}) begin
      n_err++;
      $display("FAIL ext_break: kv=%0d out=%h want 1 %h", kv_cnt - kv0, {last_change, key_extended, key_make, any_key_down}, {8'h75, 3'b101});
    end
    send_frame(8'hE0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    n_cmp++;
    if (any_key_down !== 1'b1 || key_extended !== 1'b1) begin
      n_err++;
      $display("FAIL ext_map: any=%b ext=%b want 1 1", any_key_down, key_extended);
    end
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    n_cmp++;
    if ({last_change, key_extended, key_make, any_key_down} !== {8'h1C, 3'b000}) begin
      n_err++;
      $display("FAIL ext_release: got %h want %h", {last_change, key_extended, key_make, any_key_down}, {8'h1C, 3'b000});
    end
  endtask

  task automatic test_stop_err();
    mark();
    send_frame(8'h1D, 1'b0, 1'b0);
    n_cmp++;
    if (kv_cnt - kv0 !== 0 || fe_cnt - fe0 !== 1 || last_change !== 8'h1C) begin
      n_err++;
      $display("FAIL stop_err: kv=%0d fe=%0d last=%h want 0 1 1c", kv_cnt - kv0, fe_cnt - fe0, last_change);
    end
  endtask

  task automatic test_parity();
    mark();
    send_frame(8'h1D, 1'b1, 1'b1);
    n_cmp++;
`ifdef PS2_PARITY_CHECK_EN
    if (kv_cnt - kv0 !== 0 || fe_cnt - fe0 !== 1 || last_change !== 8'h1C) begin
      n_err++;
      $display("FAIL parity: kv=%0d fe=%0d last=%h want 0 1 1c", kv_cnt - kv0, fe_cnt - fe0, last_change);
    end
`else
    if (kv_cnt - kv0 !== 1 || fe_cnt - fe0 !== 0 || last_change !== 8'h1D || key_make !== 1'b1) begin
      n_err++;
      $display("FAIL parity: kv=%0d fe=%0d last=%h make=%b want 1 0 1d 1", kv_cnt - kv0, fe_cnt - fe0, last_change, key_make);
    end
`endif
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'h1D, 1'b1, 1'b0);
    n_cmp++;
    if (any_key_down !== 1'b0 || last_change !== 8'h1D) begin
      n_err++;
      $display("FAIL parity_clear: any=%b last=%h want 0 1d", any_key_down, last_change);
    end
  endtask

  task automatic test_timeout();
    mark();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_data = 1'b1;
    repeat (TMO + 40) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (kv_cnt - kv0 !== 0 || fe_cnt - fe0 !== 1) begin
      n_err++;
      $display("FAIL timeout_err: kv=%0d fe=%0d want 0 1", kv_cnt - kv0, fe_cnt - fe0);
    end
    mark();
    send_frame(8'h24, 1'b1, 1'b0);
    n_cmp++;
    if (kv_cnt - kv0 !== 1 || fe_cnt - fe0 !== 0 || {last_change, key_extended, key_make, any_key_down} !== {8'h24, 3'b011}) begin
      n_err++;
      $display("FAIL timeout_next: kv=%0d fe=%0d out=%h want 1 0 %h", kv_cnt - kv0, fe_cnt - fe0, {last_change, key_extended, key_make, any_key_down}, {8'h24, 3'b011});
    end
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'h24, 1'b1, 1'b0);
  endtask

  task automatic test_glitch();
    mark();
    ps2_data = 1'b0;
    @(posedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (H) @(posedge clk);
    ps2_data = 1'b1;
    repeat (H) @(posedge clk);
    send_frame(8'h1B, 1'b1, 1'b0);
    n_cmp++;
    if (kv_cnt - kv0 !== 1 || fe_cnt - fe0 !== 0 || {last_change, key_make} !== {8'h1B, 1'b1}) begin
      n_err++;
      $display("FAIL glitch: kv=%0d fe=%0d last=%h make=%b want 1 0 1b 1", kv_cnt - kv0, fe_cnt - fe0, last_change, key_make);
    end
  endtask

  task automatic test_reset_midframe();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    repeat (H) @(posedge clk);
    @(negedge clk);
    mark();
    n_cmp++;
    if ({last_change, key_extended, key_make, any_key_down} !== 11'h0) begin
      n_err++;
      $display("FAIL midrst_vals: got %h want 000", {last_change, key_extended, key_make, any_key_down});
    end
    send_frame(8'h2D, 1'b1, 1'b0);
    n_cmp++;
    if (kv_cnt - kv0 !== 1 || fe_cnt - fe0 !== 0 || {last_change, key_extended, key_make, any_key_down} !== {8'h2D, 3'b011}) begin
      n_err++;
      $display("FAIL midrst_next: kv=%0d fe=%0d out=%h want 1 0 %h", kv_cnt - kv0, fe_cnt - fe0, {last_change, key_extended, key_make, any_key_down}, {8'h2D, 3'b011});
    end
  endtask

  task automatic test_back_to_back();
    mark();
    send_frame(8'h2D, 1'b1, 1'b0);
    n_cmp++;
    if (kv_cnt - kv0 !== 1 || any_key_down !== 1'b1 || key_make !== 1'b1) begin
      n_err++;
      $display("FAIL typematic: kv=%0d any=%b make=%b want 1 1 1", kv_cnt - kv0, any_key_down, key_make);
    end
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'h2D, 1'b1, 1'b0);
    mark();
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    n_cmp++;
    if (kv_cnt - kv0 !== 1 || fe_cnt - fe0 !== 0 || {last_change, key_make, any_key_down} !== {8'h33, 2'b00}) begin
      n_err++;
      $display("FAIL unheld_break: kv=%0d fe=%0d out=%h want 1 0 %h", kv_cnt - kv0, fe_cnt - fe0, {last_change, key_make, any_key_down}, {8'h33, 2'b00});
    end
    mark();
    send_frame(8'h83, 1'b1, 1'b0);
    n_cmp++;
    if (kv_cnt - kv0 !== 1 || {last_change, key_make, any_key_down} !== {8'h83, 2'b10}) begin
      n_err++;
      $display("FAIL high_code: kv=%0d out=%h want 1 %h", kv_cnt - kv0, {last_change, key_make, any_key_down}, {8'h83, 2'b10});
    end
    mark();
    send_frame(8'hE1, 1'b1, 1'b0);
    n_cmp++;
    if (kv_cnt - kv0 !== 1 || {last_change, key_extended, any_key_down} !== {8'hE1, 2'b00}) begin
      n_err++;
      $display("FAIL e1_code: kv=%0d out=%h want 1 %h", kv_cnt - kv0, {last_change, key_extended, any_key_down}, {8'hE1, 2'b00});
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_stop_err();
    test_parity();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive equal synchronized samples required before the ps2_clk level is accepted.
REQ-002 Parameter TIMEOUT_CYC, default 100000: idle clk cycles mid-frame before the frame is aborted (1 ms at 100 MHz).
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 ps2_clk  in  1  raw PS/2 clock line, asynchronous.
REQ-006 ps2_data  in  1  raw PS/2 data line, asynchronous.
REQ-007 last_change  out  8  scan code of the most recent non-prefix byte; feeds the scan-code-to-note converter.
REQ-008 key_extended  out  1  last_change was preceded by the E0 prefix.
REQ-009 key_make  out  1  1 = press, 0 = release (F0 seen) for last_change.
REQ-010 key_valid  out  1  one-cycle pulse when last_change, key_extended and key_make update.
REQ-011 any_key_down  out  1  at least one tracked key is held.
REQ-012 frame_err  out  1  one-cycle pulse on a discarded frame.

Function
REQ-013 ps2_clk and ps2_data SHALL pass through a 2-flop synchronizer; ps2_clk SHALL additionally pass the FILTER_LEN glitch filter; data is sampled on the filtered falling edge.
REQ-014 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: falling edge with data 0 -> DATA, bit count cleared; data 1 -> stay IDLE, no error.
REQ-016 DATA: shift 8 bits LSB first; after the 8th -> PARITY; PARITY: capture bit -> STOP.
REQ-017 STOP: data 1 -> byte accepted; data 0 -> frame_err pulse, byte discarded; both -> IDLE.
REQ-018 Timeout counter resets on every filtered falling edge; reaching TIMEOUT_CYC outside IDLE -> IDLE, frame_err pulse, partial byte discarded.
REQ-019 Accepted byte E0 sets ext flag; F0 sets brk flag; neither produces key_valid.
REQ-020 Any other accepted byte (including E1 and codes >= 80h) SHALL, one cycle after the stop-bit edge, drive last_change = byte, key_extended = ext, key_make = ~brk, pulse key_valid, and clear ext and brk.
REQ-021 Outputs last_change, key_extended, key_make SHALL hold until the next key_valid.
REQ-022 A 128-bit held map indexed by code[6:0] SHALL track only non-extended codes < 80h: make sets the bit, break clears it; any_key_down = OR of map, registered.
REQ-023 Repeated make (typematic) SHALL pulse key_valid again, map unchanged; break of a key not held clears nothing and raises no error.
REQ-024 frame_err SHALL NOT clear ext/brk flags; a discarded frame is otherwise invisible downstream.

Reset
REQ-025 rst_n low at a clk edge SHALL force FSM to IDLE, counters, flags, map and synchronizer/filter state to 0.
REQ-026 Reset values: last_change 00h, key_extended 0, key_make 0, key_valid 0, any_key_down 0, frame_err 0.
REQ-027 Reset mid-frame SHALL discard the partial byte without frame_err; the next frame begins only on a fresh start bit.

Configuration
REQ-028 Macro PS2_PARITY_CHECK_EN defined: odd parity over 8 data bits plus parity bit SHALL be checked in STOP; mismatch -> frame_err pulse, byte discarded even with valid stop bit.
REQ-029 PS2_PARITY_CHECK_EN undefined: parity bit captured and ignored; only start, stop and timeout errors apply.

Structure
REQ-030 Package ps2_pkg SHALL hold PS2_PREFIX_EXT (E0h), PS2_PREFIX_BREAK (F0h) and the frame-state enum type.
REQ-031 Sub-module ps2_edge_filter SHALL contain the synchronizers, glitch filter and falling-edge pulse; frame FSM, prefix decode and held map stay in ps2_key_decoder.

Verification
REQ-032 Frame 15h, correct parity -> key_valid one pulse, last_change 15h, key_make 1, key_extended 0, any_key_down 1.
REQ-033 Frames F0h, 15h -> one key_valid, last_change 15h, key_make 0, any_key_down 0; no pulse for F0h.
REQ-034 Frames E0h, F0h, 75h -> one key_valid, last_change 75h, key_extended 1, key_make 0; map unchanged.
REQ-035 Frame 1Dh with stop bit 0 -> frame_err pulse, no key_valid, last_change unchanged; with PS2_PARITY_CHECK_EN, frame 1Dh with flipped parity -> same response, without it -> key_valid, last_change 1Dh.
REQ-036 Stop ps2_clk after 4 data bits for TIMEOUT_CYC cycles -> frame_err pulse, FSM IDLE; following frame 24h decodes normally.
REQ-037 2-cycle glitch on ps2_clk during IDLE -> no state change; rst_n low mid-frame then frame 2Dh -> last_change 2Dh, no frame_err.
